morty_mem_stage: RTL and testbench

//  MEM stage: consumes the EX/MEM register outputs, runs loads/stores on a Wishbone-classic data master port and holds the MEM/WB register.

---
 rtl/morty_mem_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_morty_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morty_mem_stage.sv
// MEM stage: runs loads/stores on a Wishbone-classic data master and holds the MEM/WB register.
// Optional bus timeout enabled by defining MORTY_MEM_TIMEOUT_EN.
module morty_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_flush_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_store_data_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [5:0]  mem_mem_flags_i,
    input  logic [3:0]  mem_exception_i,
    input  logic [31:0] mem_exc_data_i,
    input  logic        mem_trap_valid_i,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i,
    output logic        mem_stall_o,
    output logic [31:0] mem_fwd_dat_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_exception_o,
    output logic [31:0] wb_exc_data_o,
    output logic        wb_trap_valid_o
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_load;
    logic        w_store;
    logic        w_unsigned;
    logic        w_size_b;
    logic        w_size_h;
    logic        w_size_w;
    logic        w_misaligned;
    logic        w_access;
    logic        w_in_bus;
    logic        w_timeout;
    logic        w_start;
    logic        w_done;
    logic        w_bus_fail;
    logic        w_stall;
    logic        w_flush_eff;
    logic [3:0]  w_sel;
    logic [31:0] w_dat;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic        w_unused_flag;

    logic        r_cyc;
    logic [31:0] r_addr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_flushed;

    logic [31:0] r_wb_pc;
    logic [31:0] r_wb_result;
    logic [4:0]  r_wb_waddr;
    logic        r_wb_we;
    logic [3:0]  r_wb_exception;
    logic [31:0] r_wb_exc_data;
    logic        r_wb_trap_valid;

    assign w_load        = mem_mem_flags_i[0];
    assign w_store       = mem_mem_flags_i[1];
    assign w_unsigned    = mem_mem_flags_i[2];
    assign w_size_b      = (mem_mem_flags_i[4:3] == 2'b00);
    assign w_size_h      = (mem_mem_flags_i[4:3] == 2'b01);
    assign w_size_w      = mem_mem_flags_i[4];
    assign w_unused_flag = mem_mem_flags_i[5];

    assign w_misaligned = (w_load | w_store) &
                          ((w_size_h & mem_result_i[0]) | (w_size_w & (|mem_result_i[1:0])));
    assign w_access     = (w_load | w_store) & ~mem_trap_valid_i & ~mem_flush_i & ~w_misaligned;
    assign w_in_bus     = (r_state == S_BUS);

`ifdef MORTY_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_tcount;

    // Counter idles at zero so it is already cleared when BUS is entered
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_tcount <= '0;
        else if (!w_in_bus)
            r_tcount <= '0;
        else
            r_tcount <= r_tcount + 1'b1;
    end

    assign w_timeout = w_in_bus & ~dwbm_ack_i & ~dwbm_err_i &
                       (r_tcount == CW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_next = S_BUS;
            S_BUS:   if (w_done)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_done     = 1'b0;
        w_bus_fail = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_access;
                w_stall = w_access;
            end
            S_BUS: begin
                w_done     = dwbm_ack_i | dwbm_err_i | w_timeout;
                w_bus_fail = dwbm_err_i | w_timeout;
                w_stall    = ~w_done;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sel = 4'b1111;
        w_dat = mem_store_data_i;
        if (w_size_b) begin
            w_sel = 4'b0001 << mem_result_i[1:0];
            w_dat = {4{mem_store_data_i[7:0]}};
        end else if (w_size_h) begin
            w_sel = 4'b0011 << mem_result_i[1:0];
            w_dat = {2{mem_store_data_i[15:0]}};
        end
    end

    // The EX/MEM inputs are frozen by the stall, so the live address picks the read lane
    assign w_shifted = dwbm_dat_i >> {mem_result_i[1:0], 3'b000};

    always_comb begin
        w_load_data = dwbm_dat_i;
        if (w_size_b)
            w_load_data = w_unsigned ? {24'h0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
        else if (w_size_h)
            w_load_data = w_unsigned ? {16'h0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cyc  <= 1'b0;
            r_addr <= '0;
            r_dat  <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
        end else if (w_start) begin
            r_cyc  <= 1'b1;
            r_addr <= {mem_result_i[31:2], 2'b00};
            r_dat  <= w_dat;
            r_sel  <= w_sel;
            r_we   <= w_store;
        end else if (w_done) begin
            r_cyc  <= 1'b0;
        end
    end

    // A flush seen mid-cycle must still turn the eventual completion into a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_flushed <= 1'b0;
        else if (w_start)
            r_flushed <= 1'b0;
        else if (w_in_bus && mem_flush_i)
            r_flushed <= 1'b1;
    end

    assign w_flush_eff = mem_flush_i | (w_in_bus & r_flushed);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb_pc         <= '0;
            r_wb_result     <= '0;
            r_wb_waddr      <= '0;
            r_wb_we         <= 1'b0;
            r_wb_exception  <= '0;
            r_wb_exc_data   <= '0;
            r_wb_trap_valid <= 1'b0;
        end else if (!w_stall) begin
            r_wb_pc    <= mem_pc_i;
            r_wb_waddr <= mem_waddr_i;
            if (w_flush_eff) begin
                r_wb_result     <= '0;
                r_wb_we         <= 1'b0;
                r_wb_exception  <= '0;
                r_wb_exc_data   <= '0;
                r_wb_trap_valid <= 1'b0;
            end else if (mem_trap_valid_i) begin
                r_wb_result     <= mem_result_i;
                r_wb_we         <= 1'b0;
                r_wb_exception  <= mem_exception_i;
                r_wb_exc_data   <= mem_exc_data_i;
                r_wb_trap_valid <= 1'b1;
            end else if (w_misaligned) begin
                r_wb_result     <= mem_result_i;
                r_wb_we         <= 1'b0;
                r_wb_exception  <= w_store ? 4'd6 : 4'd4;
                r_wb_exc_data   <= mem_result_i;
                r_wb_trap_valid <= 1'b1;
            end else if (w_bus_fail) begin
                r_wb_result     <= mem_result_i;
                r_wb_we         <= 1'b0;
                r_wb_exception  <= w_store ? 4'd7 : 4'd5;
                r_wb_exc_data   <= mem_result_i;
                r_wb_trap_valid <= 1'b1;
            end else begin
                r_wb_result     <= (w_in_bus & w_load) ? w_load_data : mem_result_i;
                r_wb_we         <= mem_we_i & ~w_store;
                r_wb_exception  <= '0;
                r_wb_exc_data   <= '0;
                r_wb_trap_valid <= 1'b0;
            end
        end
    end

    assign mem_stall_o     = w_stall;
    assign mem_fwd_dat_o   = (w_in_bus & dwbm_ack_i & w_load) ? w_load_data : mem_result_i;
    assign dwbm_addr_o     = r_addr;
    assign dwbm_dat_o      = r_dat;
    assign dwbm_sel_o      = r_sel;
    assign dwbm_we_o       = r_we;
    assign dwbm_cyc_o      = r_cyc;
    assign wb_pc_o         = r_wb_pc;
    assign wb_result_o     = r_wb_result;
    assign wb_waddr_o      = r_wb_waddr;
    assign wb_we_o         = r_wb_we;
    assign wb_exception_o  = r_wb_exception;
    assign wb_exc_data_o   = r_wb_exc_data;
    assign wb_trap_valid_o = r_wb_trap_valid;

endmodule

// File: tb/tb_morty_mem_stage.sv
// Directed testbench for morty_mem_stage: loads, stores, alignment and bus faults,
// flush, reset mid-cycle and the optional MORTY_MEM_TIMEOUT_EN timeout.
module tb_morty_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_flush_i;
    logic [31:0] mem_pc_i;
    logic [31:0] mem_result_i;
    logic [31:0] mem_store_data_i;
    logic [4:0]  mem_waddr_i;
    logic        mem_we_i;
    logic [5:0]  mem_mem_flags_i;
    logic [3:0]  mem_exception_i;
    logic [31:0] mem_exc_data_i;
    logic        mem_trap_valid_i;
    logic [31:0] dwbm_addr_o;
    logic [31:0] dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o;
    logic        dwbm_cyc_o;
    logic [31:0] dwbm_dat_i;
    logic        dwbm_ack_i;
    logic        dwbm_err_i;
    logic        mem_stall_o;
    logic [31:0] mem_fwd_dat_o;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o;
    logic [3:0]  wb_exception_o;
    logic [31:0] wb_exc_data_o;
    logic        wb_trap_valid_o;

    int total = 0;
    int bad = 0;

    int          cycCnt;
    int          stallCnt;
    int          memCycles;
    bit          done;
    logic [3:0]  obsSel;
    logic [31:0] obsDat;
    logic [31:0] obsAddr;
    logic        obsWe;
    logic [31:0] obsFwd;

    localparam logic [5:0] F_NONE = 6'h00;
    localparam logic [5:0] F_LB   = 6'h01;
    localparam logic [5:0] F_LBU  = 6'h05;
    localparam logic [5:0] F_LH   = 6'h09;
    localparam logic [5:0] F_LW   = 6'h11;
    localparam logic [5:0] F_SH   = 6'h0A;
    localparam logic [5:0] F_SW   = 6'h12;

    morty_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_flush_i(mem_flush_i),
        .mem_pc_i(mem_pc_i), .mem_result_i(mem_result_i),
        .mem_store_data_i(mem_store_data_i), .mem_waddr_i(mem_waddr_i),
        .mem_we_i(mem_we_i), .mem_mem_flags_i(mem_mem_flags_i),
        .mem_exception_i(mem_exception_i), .mem_exc_data_i(mem_exc_data_i),
        .mem_trap_valid_i(mem_trap_valid_i),
        .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_we_o(dwbm_we_o), .dwbm_cyc_o(dwbm_cyc_o), .dwbm_dat_i(dwbm_dat_i),
        .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i),
        .mem_stall_o(mem_stall_o), .mem_fwd_dat_o(mem_fwd_dat_o),
        .wb_pc_o(wb_pc_o), .wb_result_o(wb_result_o), .wb_waddr_o(wb_waddr_o),
        .wb_we_o(wb_we_o), .wb_exception_o(wb_exception_o),
        .wb_exc_data_o(wb_exc_data_o), .wb_trap_valid_o(wb_trap_valid_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one EX/MEM instruction on the stage inputs
    task automatic applyStimulus(input logic [5:0] flags, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic we);
        mem_mem_flags_i  = flags;
        mem_result_i     = addr;
        mem_store_data_i = sdata;
        mem_we_i         = we;
        mem_pc_i         = 32'h0000_1000 + addr;
        mem_waddr_i      = 5'd9;
        mem_trap_valid_i = 1'b0;
        mem_exception_i  = 4'd0;
        mem_exc_data_i   = 32'h0;
        mem_flush_i      = 1'b0;
    endtask

    task automatic setIdle();
        mem_mem_flags_i  = F_NONE;
        mem_we_i         = 1'b0;
        mem_trap_valid_i = 1'b0;
        mem_flush_i      = 1'b0;
        mem_result_i     = 32'h0;
    endtask

    // Acts as the bus slave: answers on the respAt-th cycle with CYC high (0 = never),
    // pulses flush on the flushAt-th such cycle, and stops once the stage stops stalling
    task automatic runBus(input int respAt, input bit useErr, input int flushAt,
                          input int maxCycles);
        cycCnt = 0; stallCnt = 0; memCycles = 0; done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            dwbm_ack_i  = 1'b0;
            dwbm_err_i  = 1'b0;
            mem_flush_i = 1'b0;
            if (dwbm_cyc_o) begin
                cycCnt++;
                if (cycCnt == 1) begin
                    obsSel = dwbm_sel_o; obsDat = dwbm_dat_o;
                    obsAddr = dwbm_addr_o; obsWe = dwbm_we_o;
                end
                if (cycCnt == flushAt) mem_flush_i = 1'b1;
                if (cycCnt == respAt) begin
                    if (useErr) dwbm_err_i = 1'b1;
                    else        dwbm_ack_i = 1'b1;
                end
            end
            #1;
            memCycles++;
            obsFwd = mem_fwd_dat_o;
            if (mem_stall_o) stallCnt++;
            else             done = 1;
            @(posedge clk_i); #1;
        end
        dwbm_ack_i  = 1'b0;
        dwbm_err_i  = 1'b0;
        mem_flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0; dwbm_dat_i = 32'h0;
        applyStimulus(F_NONE, 32'h0, 32'h0, 1'b0);
        mem_pc_i = 32'h0; mem_waddr_i = 5'd0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (dwbm_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_cyc: got %b want 0", dwbm_cyc_o); end
        total++; if (mem_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", mem_stall_o); end
        total++; if ({wb_pc_o, wb_result_o, wb_we_o, wb_trap_valid_o, wb_exception_o} !== 70'h0)
            begin bad++; $display("[TB] FAIL reset_wb: got pc=%h res=%h we=%b trap=%b exc=%0d want all 0",
                                  wb_pc_o, wb_result_o, wb_we_o, wb_trap_valid_o, wb_exception_o); end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        total++; if (dwbm_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_cyc: got %b want 0", dwbm_cyc_o); end
    endtask

    task automatic test_passthrough();
        applyStimulus(F_NONE, 32'h1234_5678, 32'h0, 1'b1);
        #1;
        total++; if (mem_fwd_dat_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL pass_fwd: got %h want 12345678", mem_fwd_dat_o); end
        total++; if (mem_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL pass_stall: got %b want 0", mem_stall_o); end
        @(posedge clk_i); #1;
        setIdle();
        total++; if (wb_result_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL pass_result: got %h want 12345678", wb_result_o); end
        total++; if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd9) begin bad++; $display("[TB] FAIL pass_we: got we=%b waddr=%0d want we=1 waddr=9", wb_we_o, wb_waddr_o); end
        total++; if (wb_pc_o !== 32'h1234_6678) begin bad++; $display("[TB] FAIL pass_pc: got %h want 12346678", wb_pc_o); end
    endtask

    task automatic test_load_word();
        dwbm_dat_i = 32'hDEAD_BEEF;
        applyStimulus(F_LW, 32'h0000_0100, 32'h0, 1'b1);
        runBus(3, 1'b0, 0, 20);
        setIdle();
        total++; if (cycCnt !== 3) begin bad++; $display("[TB] FAIL lw_cyc_cycles: got %0d want 3", cycCnt); end
        // One IDLE cycle plus three BUS cycles; stall drops in the ack cycle
        total++; if (memCycles !== 4 || stallCnt !== 3) begin bad++; $display("[TB] FAIL lw_latency: got mem=%0d stall=%0d want 4/3", memCycles, stallCnt); end
        total++; if (obsAddr !== 32'h100 || obsSel !== 4'b1111 || obsWe !== 1'b0)
            begin bad++; $display("[TB] FAIL lw_bus: got addr=%h sel=%b we=%b want 100/1111/0", obsAddr, obsSel, obsWe); end
        total++; if (wb_result_o !== 32'hDEAD_BEEF || wb_we_o !== 1'b1) begin bad++; $display("[TB] FAIL lw_wb: got %h we=%b want deadbeef we=1", wb_result_o, wb_we_o); end
        total++; if (dwbm_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL lw_cyc_drop: got %b want 0", dwbm_cyc_o); end
    endtask

    task automatic test_load_byte();
        dwbm_dat_i = 32'h8000_0000;
        applyStimulus(F_LB, 32'h0000_0103, 32'h0, 1'b1);
        runBus(1, 1'b0, 0, 20);
        setIdle();
        total++; if (obsSel !== 4'b1000 || obsAddr !== 32'h100) begin bad++; $display("[TB] FAIL lb_sel: got sel=%b addr=%h want 1000/100", obsSel, obsAddr); end
        total++; if (wb_result_o !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_result: got %h want ffffff80", wb_result_o); end
        total++; if (obsFwd !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_fwd: got %h want ffffff80", obsFwd); end
        total++; if (memCycles !== 2 || cycCnt !== 1) begin bad++; $display("[TB] FAIL lb_min_latency: got mem=%0d cyc=%0d want 2/1", memCycles, cycCnt); end
        applyStimulus(F_LBU, 32'h0000_0103, 32'h0, 1'b1);
        runBus(1, 1'b0, 0, 20);
        setIdle();
        total++; if (wb_result_o !== 32'h0000_0080) begin bad++; $display("[TB] FAIL lbu_result: got %h want 00000080", wb_result_o); end
        // Bytes are never misaligned
        dwbm_dat_i = 32'h0000_7F00;
        applyStimulus(F_LB, 32'h0000_0101, 32'h0, 1'b1);
        runBus(1, 1'b0, 0, 20);
        setIdle();
        total++; if (obsSel !== 4'b0010 || wb_result_o !== 32'h0000_007F || wb_trap_valid_o !== 1'b0)
            begin bad++; $display("[TB] FAIL lb_odd: got sel=%b res=%h trap=%b want 0010/7f/0", obsSel, wb_result_o, wb_trap_valid_o); end
    endtask

    task automatic test_store_half();
        applyStimulus(F_SH, 32'h0000_0202, 32'h1234_ABCD, 1'b1);
        runBus(1, 1'b0, 0, 20);
        setIdle();
        total++; if (obsSel !== 4'b1100) begin bad++; $display("[TB] FAIL sh_sel: got %b want 1100", obsSel); end
        total++; if (obsDat !== 32'hABCD_ABCD || obsWe !== 1'b1) begin bad++; $display("[TB] FAIL sh_dat: got %h we=%b want abcdabcd we=1", obsDat, obsWe); end
        total++; if (wb_we_o !== 1'b0) begin bad++; $display("[TB] FAIL sh_wb_we: got %b want 0", wb_we_o); end
    endtask

    task automatic test_misaligned();
        applyStimulus(F_LW, 32'h0000_0102, 32'h0, 1'b1);
        runBus(1, 1'b0, 0, 5);
        setIdle();
        total++; if (cycCnt !== 0 || stallCnt !== 0) begin bad++; $display("[TB] FAIL mis_lw_bus: got cyc=%0d stall=%0d want 0/0", cycCnt, stallCnt); end
        total++; if (wb_exception_o !== 4'd4 || wb_exc_data_o !== 32'h102 || wb_trap_valid_o !== 1'b1 || wb_we_o !== 1'b0)
            begin bad++; $display("[TB] FAIL mis_lw_wb: got exc=%0d data=%h trap=%b we=%b want 4/102/1/0",
                                  wb_exception_o, wb_exc_data_o, wb_trap_valid_o, wb_we_o); end
        applyStimulus(F_SH, 32'h0000_0201, 32'h5555_5555, 1'b0);
        runBus(1, 1'b0, 0, 5);
        setIdle();
        total++; if (cycCnt !== 0 || wb_exception_o !== 4'd6 || wb_exc_data_o !== 32'h201)
            begin bad++; $display("[TB] FAIL mis_sh: got cyc=%0d exc=%0d data=%h want 0/6/201", cycCnt, wb_exception_o, wb_exc_data_o); end
    endtask

    task automatic test_upstream_trap();
        applyStimulus(F_LW, 32'h0000_0400, 32'h0, 1'b1);
        mem_trap_valid_i = 1'b1;
        mem_exception_i  = 4'd2;
        mem_exc_data_i   = 32'h0000_0055;
        runBus(1, 1'b0, 0, 5);
        setIdle();
        total++; if (cycCnt !== 0 || stallCnt !== 0) begin bad++; $display("[TB] FAIL trap_bus: got cyc=%0d stall=%0d want 0/0", cycCnt, stallCnt); end
        total++; if (wb_exception_o !== 4'd2 || wb_exc_data_o !== 32'h55 || wb_trap_valid_o !== 1'b1 || wb_we_o !== 1'b0)
            begin bad++; $display("[TB] FAIL trap_wb: got exc=%0d data=%h trap=%b we=%b want 2/55/1/0",
                                  wb_exception_o, wb_exc_data_o, wb_trap_valid_o, wb_we_o); end
    endtask

    task automatic test_bus_error();
        applyStimulus(F_SW, 32'h0000_0300, 32'h0BAD_F00D, 1'b0);
        runBus(2, 1'b1, 0, 20);
        setIdle();
        total++; if (cycCnt !== 2 || dwbm_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL sw_err_cyc: got cyc=%0d now=%b want 2/0", cycCnt, dwbm_cyc_o); end
        total++; if (wb_exception_o !== 4'd7 || wb_exc_data_o !== 32'h300 || wb_trap_valid_o !== 1'b1 || wb_we_o !== 1'b0)
            begin bad++; $display("[TB] FAIL sw_err_wb: got exc=%0d data=%h trap=%b we=%b want 7/300/1/0",
                                  wb_exception_o, wb_exc_data_o, wb_trap_valid_o, wb_we_o); end
        applyStimulus(F_LH, 32'h0000_0402, 32'h0, 1'b1);
        runBus(1, 1'b1, 0, 20);
        setIdle();
        total++; if (wb_exception_o !== 4'd5 || wb_exc_data_o !== 32'h402 || wb_we_o !== 1'b0)
            begin bad++; $display("[TB] FAIL lh_err_wb: got exc=%0d data=%h we=%b want 5/402/0", wb_exception_o, wb_exc_data_o, wb_we_o); end
    endtask

    task automatic test_flush();
        dwbm_dat_i = 32'hCAFE_F00D;
        applyStimulus(F_LW, 32'h0000_0100, 32'h0, 1'b1);
        runBus(3, 1'b0, 1, 20);
        setIdle();
        total++; if (cycCnt !== 3) begin bad++; $display("[TB] FAIL flush_cyc_held: got %0d want 3", cycCnt); end
        total++; if (wb_we_o !== 1'b0 || wb_trap_valid_o !== 1'b0 || wb_exception_o !== 4'd0)
            begin bad++; $display("[TB] FAIL flush_bubble: got we=%b trap=%b exc=%0d want 0/0/0", wb_we_o, wb_trap_valid_o, wb_exception_o); end
    endtask

    task automatic test_timeout();
        applyStimulus(F_SW, 32'h0000_0500, 32'h1111_2222, 1'b0);
`ifdef MORTY_MEM_TIMEOUT_EN
        runBus(0, 1'b0, 0, 40);
        setIdle();
        total++; if (!done || cycCnt !== 16) begin bad++; $display("[TB] FAIL timeout_cycles: got done=%0d cyc=%0d want 1/16", done, cycCnt); end
        total++; if (dwbm_cyc_o !== 1'b0 || wb_exception_o !== 4'd7 || wb_exc_data_o !== 32'h500)
            begin bad++; $display("[TB] FAIL timeout_wb: got cyc=%b exc=%0d data=%h want 0/7/500", dwbm_cyc_o, wb_exception_o, wb_exc_data_o); end
`else
        runBus(0, 1'b0, 0, 25);
        total++; if (done || cycCnt !== 24 || mem_stall_o !== 1'b1)
            begin bad++; $display("[TB] FAIL no_timeout_stall: got done=%0d cyc=%0d stall=%b want 0/24/1", done, cycCnt, mem_stall_o); end
        dwbm_err_i = 1'b1;
        #1;
        total++; if (mem_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL no_timeout_err_stall: got %b want 0", mem_stall_o); end
        @(posedge clk_i); #1;
        dwbm_err_i = 1'b0;
        setIdle();
        total++; if (dwbm_cyc_o !== 1'b0 || wb_exception_o !== 4'd7 || wb_exc_data_o !== 32'h500)
            begin bad++; $display("[TB] FAIL no_timeout_wb: got cyc=%b exc=%0d data=%h want 0/7/500", dwbm_cyc_o, wb_exception_o, wb_exc_data_o); end
`endif
    endtask

    task automatic test_reset_mid_bus();
        applyStimulus(F_LW, 32'h0000_0100, 32'h0, 1'b1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        total++; if (dwbm_cyc_o !== 1'b1) begin bad++; $display("[TB] FAIL rstbus_pre_cyc: got %b want 1", dwbm_cyc_o); end
        rst_i = 1'b0;
        #1;
        total++; if (dwbm_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL rstbus_cyc: got %b want 0", dwbm_cyc_o); end
        total++; if ({wb_we_o, wb_trap_valid_o, wb_exception_o, wb_exc_data_o, wb_result_o} !== 70'h0)
            begin bad++; $display("[TB] FAIL rstbus_wb: got we=%b trap=%b exc=%0d data=%h res=%h want all 0",
                                  wb_we_o, wb_trap_valid_o, wb_exception_o, wb_exc_data_o, wb_result_o); end
        setIdle();
        #1;
        total++; if (mem_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL rstbus_stall: got %b want 0", mem_stall_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        total++; if (dwbm_cyc_o !== 1'b0 || mem_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL rstbus_after: got cyc=%b stall=%b want 0/0", dwbm_cyc_o, mem_stall_o); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_upstream_trap();
        test_bus_error();
        test_flush();
        test_timeout();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
